mips_mc_sequencer: RTL and testbench
====================================

Name: mips_mc_sequencer

Overview:
- Multi-cycle control sequencer for the mini-MIPS datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Consumes the class flags from the instruction decoder and the ALU branch-compare result.
- Drives the instruction-memory and data-memory request/ready handshakes, register-file write enable, and PC update select. Counts retired instructions and flags faults.

Parameters:
CNT_W, 32, width of the retired-instruction counter.
TIMEOUT, 255, maximum consecutive wait cycles on a memory handshake before faulting (minimum 1).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin execution; honoured only in IDLE or FAULT
halt_req  in  1  request to stop after the current instruction commits; sticky until taken
imem_ready  in  1  instruction memory has returned the word
dmem_ready  in  1  data memory access complete
mem_read  in  1  decoder class flag: load
mem_write  in  1  decoder class flag: store
reg_write  in  1  decoder class flag: writes the register file
is_branch  in  1  decoder: any conditional branch
branch_taken  in  1  ALU compare result; valid in EXEC
jump  in  1  decoder: j or jal
jump_reg  in  1  decoder: jr
link  in  1  decoder: jal
illegal  in  1  decoder: unsupported opcode or funct
imem_req  out  1  instruction fetch request
ir_load  out  1  latch the instruction register
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write qualifier
alu_en  out  1  ALU operand/result capture
rf_we  out  1  register-file write enable
pc_write  out  1  update PC this cycle
pc_sel  out  2  PC source: 00 pc+4, 01 branch target, 10 jump target, 11 rs register
state  out  3  current state encoding
retired  out  CNT_W  committed instruction count
fault  out  1  sequencer in FAULT

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0; retired=0; wait counter, sticky halt and latched class flags cleared.
  - Reset mid-handshake drops imem_req/dmem_req immediately.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6. Code 7 is unreachable and recovers to IDLE.
- IDLE: start -> FETCH.
- FETCH:
  - imem_req=1 is held until imem_ready.
  - ir_load = FETCH & imem_ready (combinational, 1 cycle), then -> DECODE.
- DECODE:
  - Registers mem_read, mem_write, reg_write, is_branch, jump, jump_reg, link; later states use only these copies.
  - illegal=1 -> FAULT; otherwise -> EXEC.
- EXEC: alu_en=1 for exactly one cycle. Next state:
  - load or store -> MEM.
  - is_branch: commit here; pc_sel=01 if branch_taken else 00 (Mealy on branch_taken).
  - jump_reg: commit here; pc_sel=11.
  - jump without link: commit here; pc_sel=10.
  - link: -> WB.
  - otherwise (reg_write) -> WB.
  - No class flag set: commit here as a NOP with pc_sel=00.
- MEM:
  - dmem_req=1, dmem_we=latched mem_write, both held stable until dmem_ready.
  - On dmem_ready: load -> WB; store commits here.
- WB: rf_we=1 for one cycle, then commit. pc_sel=10 if latched link else 00.
- Commit cycle:
  - pc_write=1 exactly once per instruction; retired increments by 1 (wraps modulo 2^CNT_W).
  - Next state is IDLE if the sticky halt is set (halt cleared), else FETCH.
  - halt_req asserted in the commit cycle itself is taken in that same cycle.
- Wait counter (FETCH and MEM only):
  - Counts cycles with request high and ready low; cleared on state entry.
  - Reaching TIMEOUT -> FAULT, request dropped.
  - ready in the same cycle the count hits TIMEOUT: ready wins and no fault occurs.
- FAULT:
  - fault=1; no requests, pc_write=0, retired frozen.
  - start -> IDLE with fault cleared.
- start outside IDLE/FAULT is ignored.
- Latency with zero-wait memory:
  - ALU op = 4 cycles; load = 5; store = 4; branch/j/jr = 3; jal = 4.
  - Each memory wait cycle adds 1.

Test Plan:
- add after start, imem_ready tied 1: state sequence 1,2,3,5; rf_we in cycle 4 only; pc_write with pc_sel=00 in cycle 4; retired 0->1.
- lw with dmem_ready delayed 3 cycles: dmem_req high 4 cycles, dmem_we=0, WB follows, total 8 cycles, retired=1.
- beq in EXEC: branch_taken=1 -> pc_sel=01, pc_write in cycle 3, no rf_we. Repeat with branch_taken=0 -> pc_sel=00.
- jal -> EXEC then WB with rf_we=1 and pc_sel=10. jr -> pc_sel=11 committed in EXEC.
- TIMEOUT=4, imem_ready held 0 -> FAULT after 4 wait cycles, fault=1, imem_req=0. Same run with ready arriving in cycle 4 -> no fault.
- halt_req pulsed during MEM of a store -> commit in MEM, then IDLE. Then illegal=1 in DECODE -> FAULT; start -> IDLE. rst_n low mid-MEM -> dmem_req=0 immediately, retired=0.

Source files
------------

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle control sequencer for the mini-MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, owns the memory
// handshakes, register-file write, PC update select and retired count.
module mips_mc_sequencer #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             is_branch,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic             link,
  input  logic             illegal,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_en,
  output logic             rf_we,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             fault
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_RS   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic is_branch;
    logic jump;
    logic jump_reg;
    logic link;
  } cls_t;

  state_e            state_q,    state_d;
  cls_t              cls_q,      cls_d;
  logic              halt_q,     halt_d;
  logic [WAIT_W-1:0] wait_q,     wait_d;
  logic [CNT_W-1:0]  retired_q,  retired_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q,  dmem_we_d;
  logic              alu_en_q,   alu_en_d;
  logic              rf_we_q,    rf_we_d;
  logic              fault_q,    fault_d;
  logic              commit;

  // Next-state, commit and handshake decisions; Mealy outputs decided here too
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    halt_d    = halt_q | halt_req;
    wait_d    = '0;
    retired_d = retired_q;
    commit    = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = PC_SEQ;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        cls_d = '{mem_read:  mem_read,
                  mem_write: mem_write,
                  reg_write: reg_write,
                  is_branch: is_branch,
                  jump:      jump,
                  jump_reg:  jump_reg,
                  link:      link};
        state_d = illegal ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        if (cls_q.mem_read || cls_q.mem_write) begin
          state_d = S_MEM;
        end else if (cls_q.is_branch) begin
          commit = 1'b1;
          pc_sel = branch_taken ? PC_BR : PC_SEQ;
        end else if (cls_q.jump_reg) begin
          commit = 1'b1;
          pc_sel = PC_RS;
        end else if (cls_q.jump && !cls_q.link) begin
          commit = 1'b1;
          pc_sel = PC_JMP;
        end else if (cls_q.link || cls_q.reg_write) begin
          state_d = S_WB;
        end else begin
          commit = 1'b1;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (cls_q.mem_write) commit  = 1'b1;
          else                 state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        commit = 1'b1;
        pc_sel = cls_q.link ? PC_JMP : PC_SEQ;
      end
      S_FAULT: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      pc_write  = 1'b1;
      retired_d = retired_q + CNT_W'(1);
      state_d   = (halt_q || halt_req) ? S_IDLE : S_FETCH;
      halt_d    = 1'b0;
    end

    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) && cls_d.mem_write;
    alu_en_d   = (state_d == S_EXEC);
    rf_we_d    = (state_d == S_WB);
    fault_d    = (state_d == S_FAULT);
  end

  // State, latched class flags, counters and registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cls_q      <= '0;
      halt_q     <= 1'b0;
      wait_q     <= '0;
      retired_q  <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      alu_en_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      halt_q     <= halt_d;
      wait_q     <= wait_d;
      retired_q  <= retired_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      alu_en_q   <= alu_en_d;
      rf_we_q    <= rf_we_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req = imem_req_q;
  assign dmem_req = dmem_req_q;
  assign dmem_we  = dmem_we_q;
  assign alu_en   = alu_en_q;
  assign rf_we    = rf_we_q;
  assign fault    = fault_q;
  assign state    = state_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Scoreboard bench for mips_mc_sequencer: per-cycle stimulus and expected
// outputs are queued together, the DUT is stepped, then observations compared.
module tb_mips_mc_sequencer;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 4;

  // class bits: {illegal, link, jump_reg, jump, is_branch, reg_write, mem_write, mem_read}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_ADD  = 8'b0000_0100;
  localparam logic [7:0] C_LW   = 8'b0000_0101;
  localparam logic [7:0] C_SW   = 8'b0000_0010;
  localparam logic [7:0] C_BEQ  = 8'b0000_1000;
  localparam logic [7:0] C_JAL  = 8'b0101_0100;
  localparam logic [7:0] C_JR   = 8'b0010_0000;
  localparam logic [7:0] C_ILL  = 8'b1000_0000;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_load;
    logic       dmem_req;
    logic       dmem_we;
    logic       alu_en;
    logic       rf_we;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       fault;
  } obs_t;

  typedef struct packed {
    logic       start;
    logic       halt;
    logic       iready;
    logic       dready;
    logic       btaken;
    logic [7:0] cls;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, halt_req, imem_ready, dmem_ready;
  logic mem_read, mem_write, reg_write, is_branch, branch_taken;
  logic jump, jump_reg, link, illegal;
  logic imem_req, ir_load, dmem_req, dmem_we, alu_en, rf_we, pc_write, fault;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] exp_retired = '0;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  obs_t  obs_q[$];

  mips_mc_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .is_branch(is_branch), .branch_taken(branch_taken), .jump(jump),
    .jump_reg(jump_reg), .link(link), .illegal(illegal),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .alu_en(alu_en), .rf_we(rf_we), .pc_write(pc_write),
    .pc_sel(pc_sel), .state(state), .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic stim_t sm(input logic st, input logic h, input logic ir,
                               input logic dr, input logic bt, input logic [7:0] c);
    stim_t s;
    s.start = st; s.halt = h; s.iready = ir; s.dready = dr; s.btaken = bt; s.cls = c;
    return s;
  endfunction

  // Expected outputs: the state alone fixes the registered ones
  function automatic obs_t ex(input int st, input logic irl, input logic pcw,
                              input logic [1:0] ps, input logic dwe);
    obs_t o;
    o.st       = 3'(st);
    o.imem_req = (st == 1);
    o.ir_load  = irl;
    o.dmem_req = (st == 4);
    o.dmem_we  = dwe;
    o.alu_en   = (st == 3);
    o.rf_we    = (st == 5);
    o.pc_write = pcw;
    o.pc_sel   = ps;
    o.fault    = (st == 6);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state; o.imem_req = imem_req; o.ir_load = ir_load; o.dmem_req = dmem_req;
    o.dmem_we = dmem_we; o.alu_en = alu_en; o.rf_we = rf_we; o.pc_write = pc_write;
    o.pc_sel = pc_sel; o.fault = fault;
    return o;
  endfunction

  task automatic step(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    start = s.start; halt_req = s.halt; imem_ready = s.iready; dmem_ready = s.dready;
    branch_taken = s.btaken;
    {illegal, link, jump_reg, jump, is_branch, reg_write, mem_write, mem_read} = s.cls;
  endtask

  // Drive queued stimulus one cycle at a time, recording outputs mid-cycle
  task automatic run_cycles();
    stim_t s;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      @(negedge clk);
      obs_q.push_back(sample());
      @(posedge clk);
      #1;
    end
    apply(sm(0, 0, 0, 0, 0, C_NONE));
  endtask

  task automatic test_reset();
    obs_t g;
    rst_n = 1'b0;
    apply(sm(0, 0, 0, 0, 0, C_NONE));
    repeat (2) @(posedge clk);
    #1;
    g = sample();
    n_checks++;
    if (g !== ex(0, 0, 0, 2'b00, 0)) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=%b", g, ex(0, 0, 0, 2'b00, 0));
    end
    n_checks++;
    if (retired !== '0) begin n_fail++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    g = sample();
    n_checks++;
    if (g !== ex(0, 0, 0, 2'b00, 0)) begin
      n_fail++; $display("FAIL reset_idle got=%b exp=%b", g, ex(0, 0, 0, 2'b00, 0));
    end
  endtask

  task automatic test_alu();
    obs_t e, g;
    int c = 0;
    step(sm(1, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(1, 1, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_ADD),  ex(2, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(3, 0, 0, 2'b00, 0));
    step(sm(0, 1, 1, 0, 0, C_NONE), ex(5, 0, 1, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    exp_retired++;
    run_cycles();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL alu cyc%0d got=%b exp=%b", c, g, e); end
      c++;
    end
    n_checks++;
    if (retired !== exp_retired) begin
      n_fail++; $display("FAIL alu_retired got=%0d exp=%0d", retired, exp_retired);
    end
  endtask

  task automatic test_load();
    obs_t e, g;
    int c = 0;
    step(sm(1, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(1, 1, 0, 2'b00, 0));
    step(sm(0, 0, 0, 0, 0, C_LW),   ex(2, 0, 0, 2'b00, 0));
    step(sm(0, 0, 0, 0, 0, C_NONE), ex(3, 0, 0, 2'b00, 0));
    for (int i = 0; i < 3; i++) step(sm(0, 0, 0, 0, 0, C_NONE), ex(4, 0, 0, 2'b00, 0));
    step(sm(0, 0, 0, 1, 0, C_NONE), ex(4, 0, 0, 2'b00, 0));
    step(sm(0, 1, 0, 0, 0, C_NONE), ex(5, 0, 1, 2'b00, 0));
    step(sm(0, 0, 0, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    exp_retired++;
    run_cycles();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL load cyc%0d got=%b exp=%b", c, g, e); end
      c++;
    end
    n_checks++;
    if (retired !== exp_retired) begin
      n_fail++; $display("FAIL load_retired got=%0d exp=%0d", retired, exp_retired);
    end
  endtask

  // Taken branch then not-taken branch with no IDLE gap between them
  task automatic test_back_to_back();
    obs_t e, g;
    int c = 0;
    step(sm(1, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(1, 1, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_BEQ),  ex(2, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 1, C_NONE), ex(3, 0, 1, 2'b01, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(1, 1, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_BEQ),  ex(2, 0, 0, 2'b00, 0));
    step(sm(0, 1, 1, 0, 0, C_NONE), ex(3, 0, 1, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    exp_retired += 2;
    run_cycles();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL branch cyc%0d got=%b exp=%b", c, g, e); end
      c++;
    end
    n_checks++;
    if (retired !== exp_retired) begin
      n_fail++; $display("FAIL branch_retired got=%0d exp=%0d", retired, exp_retired);
    end
  endtask

  task automatic test_jump();
    obs_t e, g;
    int c = 0;
    step(sm(1, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(1, 1, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_JAL),  ex(2, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(3, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(5, 0, 1, 2'b10, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(1, 1, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_JR),   ex(2, 0, 0, 2'b00, 0));
    step(sm(0, 1, 1, 0, 0, C_NONE), ex(3, 0, 1, 2'b11, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    exp_retired += 2;
    run_cycles();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL jump cyc%0d got=%b exp=%b", c, g, e); end
      c++;
    end
    n_checks++;
    if (retired !== exp_retired) begin
      n_fail++; $display("FAIL jump_retired got=%0d exp=%0d", retired, exp_retired);
    end
  endtask

  task automatic test_timeout();
    obs_t e, g;
    int c = 0;
    // fetch never answered: four wait cycles, then FAULT
    step(sm(1, 0, 0, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    for (int i = 0; i < 4; i++) step(sm(0, 0, 0, 0, 0, C_NONE), ex(1, 0, 0, 2'b00, 0));
    step(sm(1, 0, 0, 0, 0, C_NONE), ex(6, 0, 0, 2'b00, 0));
    // ready on the last allowed cycle wins; NOP commits in EXEC
    step(sm(1, 0, 0, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    for (int i = 0; i < 3; i++) step(sm(0, 0, 0, 0, 0, C_NONE), ex(1, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(1, 1, 0, 2'b00, 0));
    step(sm(0, 0, 0, 0, 0, C_NONE), ex(2, 0, 0, 2'b00, 0));
    step(sm(0, 1, 0, 0, 0, C_NONE), ex(3, 0, 1, 2'b00, 0));
    // store never acknowledged: four MEM cycles, then FAULT
    step(sm(1, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(1, 1, 0, 2'b00, 0));
    step(sm(0, 0, 0, 0, 0, C_SW),   ex(2, 0, 0, 2'b00, 0));
    step(sm(0, 0, 0, 0, 0, C_NONE), ex(3, 0, 0, 2'b00, 0));
    for (int i = 0; i < 4; i++) step(sm(0, 0, 0, 0, 0, C_NONE), ex(4, 0, 0, 2'b00, 1));
    step(sm(0, 0, 0, 0, 0, C_NONE), ex(6, 0, 0, 2'b00, 0));
    step(sm(1, 0, 0, 0, 0, C_NONE), ex(6, 0, 0, 2'b00, 0));
    step(sm(0, 0, 0, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    exp_retired++;
    run_cycles();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL timeout cyc%0d got=%b exp=%b", c, g, e); end
      c++;
    end
    n_checks++;
    if (retired !== exp_retired) begin
      n_fail++; $display("FAIL timeout_retired got=%0d exp=%0d", retired, exp_retired);
    end
  endtask

  task automatic test_halt_fault();
    obs_t e, g;
    int c = 0;
    // halt pulsed early in MEM of a store: commit in MEM, then IDLE
    step(sm(1, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(1, 1, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_SW),   ex(2, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(3, 0, 0, 2'b00, 0));
    step(sm(0, 1, 1, 0, 0, C_NONE), ex(4, 0, 0, 2'b00, 1));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(4, 0, 0, 2'b00, 1));
    step(sm(0, 0, 1, 1, 0, C_NONE), ex(4, 0, 1, 2'b00, 1));
    // illegal opcode; start in FETCH is ignored; FAULT holds until start
    step(sm(1, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    step(sm(1, 0, 1, 0, 0, C_NONE), ex(1, 1, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_ILL),  ex(2, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(6, 0, 0, 2'b00, 0));
    step(sm(1, 0, 1, 0, 0, C_NONE), ex(6, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    exp_retired++;
    run_cycles();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL halt_fault cyc%0d got=%b exp=%b", c, g, e); end
      c++;
    end
    n_checks++;
    if (retired !== exp_retired) begin
      n_fail++; $display("FAIL halt_fault_retired got=%0d exp=%0d", retired, exp_retired);
    end
  endtask

  task automatic test_reset_mid_mem();
    obs_t e, g;
    int c = 0;
    step(sm(1, 0, 1, 0, 0, C_NONE), ex(0, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(1, 1, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_SW),   ex(2, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(3, 0, 0, 2'b00, 0));
    step(sm(0, 0, 1, 0, 0, C_NONE), ex(4, 0, 0, 2'b00, 1));
    run_cycles();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL rst_mem cyc%0d got=%b exp=%b", c, g, e); end
      c++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_dmem_req got=%b exp=0", dmem_req); end
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL rst_mem_state got=%0d exp=0", state); end
    n_checks++;
    if (retired !== '0) begin n_fail++; $display("FAIL rst_mem_retired got=%0d exp=0", retired); end
    exp_retired = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_jump();
    test_timeout();
    test_halt_fault();
    test_reset_mid_mem();
    test_alu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
